conv_frame_seq: RTL and testbench
=================================

CONV_FRAME_SEQ -- requirements
Module: conv_frame_seq

Interface
REQ-001 SHALL have parameter PIXEL_W, default conv_pkg::PIXEL_W, pixel data width.
REQ-002 SHALL have parameter DIM_W, default 12, width of frame-dimension fields and counters.
REQ-003 SHALL have ports, in this order:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- en_i  input  1  frame enable; sampled only in IDLE.
- cfg_width_i  input  DIM_W  pixels per line.
- cfg_height_i  input  DIM_W  lines per frame.
- s_tvalid_i  input  1  upstream pixel valid.
- s_tdata_i  input  PIXEL_W  upstream pixel.
- s_tuser_i  input  1  upstream SOF marker (checked only, never forwarded).
- s_tlast_i  input  1  upstream EOL marker (checked only, never forwarded).
- s_tready_o  output  1  upstream ready.
- m_tvalid_o  output  1  downstream valid.
- m_tdata_o  output  PIXEL_W  downstream pixel.
- m_tuser_o  output  1  downstream SOF.
- m_tlast_o  output  1  downstream EOL.
- m_tdrain_o  output  1  beat is a flush beat, not image data.
- m_tready_i  input  1  downstream ready.
- busy_o  output  1  state != IDLE.
- frame_done_o  output  1  one-cycle pulse when the last drain beat is accepted downstream.
- err_o  output  2  sticky: [0] config rejected, [1] marker mismatch.

Function
REQ-004 SHALL implement FSM IDLE, ACTIVE, DRAIN; reset state IDLE.
REQ-005 IDLE: en_i=1 with cfg_width_i>=2 and cfg_height_i>=2 SHALL latch both into internal registers, clear column/row counters, go ACTIVE next cycle.
REQ-006 IDLE: en_i=1 with either dimension <2 SHALL stay IDLE and set err_o[0].
REQ-007 Latched dimensions SHALL NOT change until the FSM next reaches IDLE; cfg_* changes mid-frame are ignored.
REQ-008 Output SHALL be a single registered slice: accepted beat appears on m_* exactly one cycle after acceptance; m_* held stable while m_tvalid_o=1 and m_tready_i=0.
REQ-009 s_tready_o SHALL equal (state==ACTIVE) & (~m_tvalid_o | m_tready_i); zero in IDLE and DRAIN.
REQ-010 Upstream accept = s_tvalid_i & s_tready_o; each accept SHALL advance column counter; column wraps width-1 -> 0 and increments row.
REQ-011 For accepted beats: m_tuser_o = (col==0 & row==0); m_tlast_o = (col==width-1); m_tdrain_o=0; m_tdata_o = s_tdata_i.
REQ-012 Accepting pixel at col==width-1, row==height-1 SHALL transition to DRAIN and reset the drain counter and column counter to 0.
REQ-013 DRAIN SHALL emit exactly 2*width+2 beats, one whenever the output slot is free, with m_tdata_o=0, m_tuser_o=0, m_tdrain_o=1, m_tlast_o=(col==width-1), column counter continuing to wrap.
REQ-014 On acceptance of the final drain beat SHALL pulse frame_done_o for one cycle and go IDLE; if en_i still 1, REQ-005 applies on the following cycle.
REQ-015 Counter arithmetic SHALL be DIM_W-bit unsigned; drain counter DIM_W+2 bits; no overflow for any legal configuration.
REQ-016 Simultaneous output drain (m_tready_i=1) and new accept SHALL sustain one beat per cycle with no bubble.
REQ-017 err_o bits SHALL be sticky until rst.

Reset
REQ-018 rst=1 SHALL, on the next clock edge, force IDLE, m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, m_tlast_o=0, m_tdrain_o=0, frame_done_o=0, err_o=0, all counters and latched dimensions 0, regardless of state or pending handshake.
REQ-019 s_tready_o and busy_o SHALL be 0 while rst=1 and the cycle after; an in-flight beat is discarded.

Configuration
REQ-020 With macro CONV_FRAME_SEQ_CHK_EN defined: each upstream accept SHALL compare s_tuser_i to (col==0 & row==0) and s_tlast_i to (col==width-1); any mismatch sets err_o[1]; data still forwarded with generated markers.
REQ-021 Without CONV_FRAME_SEQ_CHK_EN: s_tuser_i/s_tlast_i SHALL be ignored and err_o[1] tied 0.

Verification
REQ-022 W=4,H=3, continuous valid, m_tready_i=1 -> 22 output beats back-to-back; m_tuser_o on beat 0 only; m_tlast_o on beats 3,7,11,15,19; m_tdrain_o on beats 12-21; frame_done_o one cycle after beat 21 accepted.
REQ-023 W=4,H=3, m_tready_i toggling 1/0 each cycle -> same 22-beat sequence, m_* stable on every stalled cycle, no beat lost or duplicated.
REQ-024 en_i=1, cfg_width_i=1, cfg_height_i=8 -> FSM stays IDLE, err_o=2'b01, s_tready_o=0.
REQ-025 rst asserted after 6 pixels of W=4,H=3 frame -> next cycle m_tvalid_o=0, busy_o=0, err_o=0; restarted frame begins with m_tuser_o=1.
REQ-026 CHK_EN defined, W=4,H=2, s_tlast_i=1 on input pixel 2 instead of 3 -> err_o[1]=1, output m_tlast_o still on beats 3 and 7.
REQ-027 en_i held 1 across two W=2,H=2 frames -> frame_done_o pulses twice; second frame m_tuser_o=1 on its first beat; exactly 6 drain beats per frame.

Source files
------------

// File: rtl/conv_frame_seq.sv
// Frame sequencer: passes a width x height pixel frame through a registered output slice
// with generated SOF/EOL markers, then appends 2*width+2 flush beats. Optional macro: CONV_FRAME_SEQ_CHK_EN.
package conv_pkg;
    localparam int unsigned PIXEL_W = 8;
endpackage

module conv_frame_seq #(
    parameter int unsigned PIXEL_W = conv_pkg::PIXEL_W,
    parameter int unsigned DIM_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [DIM_W-1:0]   cfg_width_i,
    input  logic [DIM_W-1:0]   cfg_height_i,
    input  logic               s_tvalid_i,
    input  logic [PIXEL_W-1:0] s_tdata_i,
    input  logic               s_tuser_i,
    input  logic               s_tlast_i,
    output logic               s_tready_o,
    output logic               m_tvalid_o,
    output logic [PIXEL_W-1:0] m_tdata_o,
    output logic               m_tuser_o,
    output logic               m_tlast_o,
    output logic               m_tdrain_o,
    input  logic               m_tready_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic [1:0]         err_o
);

    localparam int unsigned DCNT_W = DIM_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIM_W-1:0]     r_width,   w_width_nxt;
    logic [DIM_W-1:0]     r_height,  w_height_nxt;
    logic [DIM_W-1:0]     r_col,     w_col_nxt;
    logic [DIM_W-1:0]     r_row,     w_row_nxt;
    logic [DCNT_W-1:0]    r_dcnt,    w_dcnt_nxt;
    logic                 r_m_tvalid, w_m_tvalid_nxt;
    logic [PIXEL_W-1:0]   r_m_tdata,  w_m_tdata_nxt;
    logic                 r_m_tuser,  w_m_tuser_nxt;
    logic                 r_m_tlast,  w_m_tlast_nxt;
    logic                 r_m_tdrain, w_m_tdrain_nxt;
    logic                 r_frame_done, w_frame_done_nxt;
    logic [1:0]           r_err,      w_err_nxt;

    logic                 w_slot_free;
    logic                 w_accept;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_first_px;
    logic [DIM_W-1:0]     w_col_inc;
    logic [DCNT_W-1:0]    w_drain_total;
    logic                 w_cfg_ok;
    logic                 w_mark_err;

    assign w_slot_free   = ~r_m_tvalid | m_tready_i;
    assign w_accept      = (r_state == S_ACTIVE) & s_tvalid_i & w_slot_free;
    assign w_col_last    = (r_col == r_width - DIM_W'(1));
    assign w_row_last    = (r_row == r_height - DIM_W'(1));
    assign w_first_px    = (r_col == '0) & (r_row == '0);
    assign w_col_inc     = w_col_last ? '0 : r_col + DIM_W'(1);
    assign w_drain_total = DCNT_W'({r_width, 1'b0}) + DCNT_W'(2);
    assign w_cfg_ok      = (cfg_width_i >= DIM_W'(2)) & (cfg_height_i >= DIM_W'(2));

`ifdef CONV_FRAME_SEQ_CHK_EN
    // Upstream markers are only compared against the generated ones, never forwarded
    assign w_mark_err = w_accept & ((s_tuser_i != w_first_px) | (s_tlast_i != w_col_last));
`else
    logic w_unused_markers;
    assign w_unused_markers = s_tuser_i ^ s_tlast_i;
    assign w_mark_err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_width_nxt      = r_width;
        w_height_nxt     = r_height;
        w_col_nxt        = r_col;
        w_row_nxt        = r_row;
        w_dcnt_nxt       = r_dcnt;
        w_m_tvalid_nxt   = r_m_tvalid & ~m_tready_i;
        w_m_tdata_nxt    = r_m_tdata;
        w_m_tuser_nxt    = r_m_tuser;
        w_m_tlast_nxt    = r_m_tlast;
        w_m_tdrain_nxt   = r_m_tdrain;
        w_frame_done_nxt = 1'b0;
        w_err_nxt        = r_err | {w_mark_err, 1'b0};

        case (r_state)
            S_IDLE: begin
                if (en_i) begin
                    if (w_cfg_ok) begin
                        w_width_nxt  = cfg_width_i;
                        w_height_nxt = cfg_height_i;
                        w_col_nxt    = '0;
                        w_row_nxt    = '0;
                        w_state_nxt  = S_ACTIVE;
                    end else begin
                        w_err_nxt[0] = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (w_accept) begin
                    w_m_tvalid_nxt = 1'b1;
                    w_m_tdata_nxt  = s_tdata_i;
                    w_m_tuser_nxt  = w_first_px;
                    w_m_tlast_nxt  = w_col_last;
                    w_m_tdrain_nxt = 1'b0;
                    w_col_nxt      = w_col_inc;
                    if (w_col_last) w_row_nxt = r_row + DIM_W'(1);
                    if (w_col_last && w_row_last) begin
                        w_col_nxt   = '0;
                        w_dcnt_nxt  = '0;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Emit flush beats until the count is reached, then wait for the last one to leave
                if (r_dcnt != w_drain_total) begin
                    if (w_slot_free) begin
                        w_m_tvalid_nxt = 1'b1;
                        w_m_tdata_nxt  = '0;
                        w_m_tuser_nxt  = 1'b0;
                        w_m_tlast_nxt  = w_col_last;
                        w_m_tdrain_nxt = 1'b1;
                        w_col_nxt      = w_col_inc;
                        w_dcnt_nxt     = r_dcnt + DCNT_W'(1);
                    end
                end else if (r_m_tvalid && m_tready_i) begin
                    w_frame_done_nxt = 1'b1;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width      <= '0;
            r_height     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_dcnt       <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tuser    <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tdrain   <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= '0;
        end else begin
            r_width      <= w_width_nxt;
            r_height     <= w_height_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_dcnt       <= w_dcnt_nxt;
            r_m_tvalid   <= w_m_tvalid_nxt;
            r_m_tdata    <= w_m_tdata_nxt;
            r_m_tuser    <= w_m_tuser_nxt;
            r_m_tlast    <= w_m_tlast_nxt;
            r_m_tdrain   <= w_m_tdrain_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Ready and busy are forced low during reset so no beat is taken while the slice is cleared
    assign s_tready_o   = ~rst & (r_state == S_ACTIVE) & w_slot_free;
    assign busy_o       = ~rst & (r_state != S_IDLE);
    assign m_tvalid_o   = r_m_tvalid;
    assign m_tdata_o    = r_m_tdata;
    assign m_tuser_o    = r_m_tuser;
    assign m_tlast_o    = r_m_tlast;
    assign m_tdrain_o   = r_m_tdrain;
    assign frame_done_o = r_frame_done;
    assign err_o        = r_err;

endmodule

// File: tb/tb_conv_frame_seq.sv
// Directed self-checking bench for conv_frame_seq.
module tb_conv_frame_seq;

    localparam int unsigned PW = 8;
    localparam int unsigned DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_i;
    logic [DW-1:0] cfg_width_i;
    logic [DW-1:0] cfg_height_i;
    logic          s_tvalid_i;
    logic [PW-1:0] s_tdata_i;
    logic          s_tuser_i;
    logic          s_tlast_i;
    logic          s_tready_o;
    logic          m_tvalid_o;
    logic [PW-1:0] m_tdata_o;
    logic          m_tuser_o;
    logic          m_tlast_o;
    logic          m_tdrain_o;
    logic          m_tready_i;
    logic          busy_o;
    logic          frame_done_o;
    logic [1:0]    err_o;

    conv_frame_seq #(.PIXEL_W(PW), .DIM_W(DW)) dut (
        .clk(clk), .rst(rst), .en_i(en_i),
        .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
        .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tuser_i(s_tuser_i),
        .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
        .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tuser_o(m_tuser_o),
        .m_tlast_o(m_tlast_o), .m_tdrain_o(m_tdrain_o), .m_tready_i(m_tready_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit rdy_toggle = 1'b0;

    logic [PW+2:0] beat_q[$];
    int            beat_cyc[$];
    int            done_cnt  = 0;
    int            done_cyc  = 0;
    int            stall_n   = 0;
    int            stall_bad = 0;
    bit            prev_stall = 1'b0;
    logic [PW+3:0] prev_bus;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_tready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready_i = rdy_toggle ? ~m_tready_i : 1'b1;
        end
    end

    // Output monitor: log accepted beats, done pulses and stall-hold violations
    always @(negedge clk) begin
        if (!rst && prev_stall) begin
            stall_n++;
            if ({m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o, m_tdrain_o} !== prev_bus) stall_bad++;
        end
        if (!rst && m_tvalid_o && m_tready_i) begin
            beat_q.push_back({m_tdata_o, m_tuser_o, m_tlast_o, m_tdrain_o});
            beat_cyc.push_back(cyc);
        end
        if (!rst && frame_done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = m_tvalid_o & ~m_tready_i & ~rst;
        prev_bus   = {m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o, m_tdrain_o};
    end

    task automatic start_frame(input int w, input int h);
        en_i         = 1'b1;
        cfg_width_i  = DW'(w);
        cfg_height_i = DW'(h);
        @(posedge clk);
        #1;
        en_i         = 1'b0;
        cfg_width_i  = DW'(15);
        cfg_height_i = DW'(15);
    endtask

    // Pixel i carries data i*17+5; bad >= 0 moves the EOL marker of that row one pixel early
    task automatic send_pixels(input int n, input int w, input int bad);
        int t;
        for (int i = 0; i < n; i++) begin
            s_tvalid_i = 1'b1;
            s_tdata_i  = PW'(i * 17 + 5);
            s_tuser_i  = (i == 0);
            s_tlast_i  = ((i % w) == w - 1);
            if (bad >= 0 && i == bad)     s_tlast_i = 1'b1;
            if (bad >= 0 && i == bad + 1) s_tlast_i = 1'b0;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!s_tready_o && t < 200);
            if (!s_tready_o) begin
                check("tready_timeout", 32'd0, 32'd1);
                s_tvalid_i = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid_i = 1'b0;
        s_tuser_i  = 1'b0;
        s_tlast_i  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic check_frame(input int base, input int w, input int h);
        int npix = w * h;
        int nd   = 2 * w + 2;
        logic [PW+2:0] exp;
        logic [PW+2:0] got;
        for (int j = 0; j < npix + nd; j++) begin
            if (j < npix) exp = {PW'(j * 17 + 5), (j == 0), ((j % w) == w - 1), 1'b0};
            else          exp = {PW'(0), 1'b0, (((j - npix) % w) == w - 1), 1'b1};
            got = (base + j < beat_q.size()) ? beat_q[base + j] : '1;
            check($sformatf("beat%0d", j), 32'(got), 32'(exp));
        end
    endtask

    int base;
    int d0;
    int sb;
    int drains;

    initial begin
        rst = 1'b1; en_i = 1'b0; cfg_width_i = '0; cfg_height_i = '0;
        s_tvalid_i = 1'b0; s_tdata_i = '0; s_tuser_i = 1'b0; s_tlast_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid_o), 32'd0);
        check("rst_busy",   32'(busy_o),     32'd0);
        check("rst_err",    32'(err_o),      32'd0);
        check("rst_tready", 32'(s_tready_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Continuous 4x3 frame with always-ready sink
        base = beat_q.size(); d0 = done_cnt;
        start_frame(4, 3);
        send_pixels(12, 4, -1);
        wait_done(d0 + 1);
        check("a_nbeats", 32'(beat_q.size() - base), 32'd22);
        check_frame(base, 4, 3);
        if (beat_cyc.size() >= base + 22) begin
            check("a_b2b",      32'(beat_cyc[base + 21] - beat_cyc[base]), 32'd21);
            check("a_done_lat", 32'(done_cyc - beat_cyc[base + 21]),       32'd1);
        end
        check("a_idle", 32'(busy_o), 32'd0);

        // Same frame with the sink stalling every other cycle
        base = beat_q.size(); d0 = done_cnt; sb = stall_n;
        rdy_toggle = 1'b1;
        start_frame(4, 3);
        send_pixels(12, 4, -1);
        wait_done(d0 + 1);
        rdy_toggle = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("b_nbeats", 32'(beat_q.size() - base), 32'd22);
        check_frame(base, 4, 3);
        check("b_stalls_seen", 32'(stall_n > sb), 32'd1);
        check("b_stall_hold",  32'(stall_bad),    32'd0);

        // Illegal width rejected
        en_i = 1'b1; cfg_width_i = DW'(1); cfg_height_i = DW'(8);
        repeat (3) @(negedge clk);
        check("c_busy",   32'(busy_o),     32'd0);
        check("c_tready", 32'(s_tready_o), 32'd0);
        check("c_err",    32'(err_o),      32'd1);
        @(posedge clk); #1;
        en_i = 1'b0;

        // Reset in the middle of a frame, then restart
        start_frame(4, 3);
        send_pixels(6, 4, -1);
        rst = 1'b1;
        @(negedge clk);
        check("d_tready_in_rst", 32'(s_tready_o), 32'd0);
        check("d_busy_in_rst",   32'(busy_o),     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("d_tvalid", 32'(m_tvalid_o), 32'd0);
        check("d_busy",   32'(busy_o),     32'd0);
        check("d_err",    32'(err_o),      32'd0);
        check("d_tready", 32'(s_tready_o), 32'd0);
        @(posedge clk); #1;
        base = beat_q.size(); d0 = done_cnt;
        start_frame(4, 3);
        send_pixels(12, 4, -1);
        wait_done(d0 + 1);
        check("d_nbeats", 32'(beat_q.size() - base), 32'd22);
        check_frame(base, 4, 3);

        // 4x2 frame with an early upstream EOL marker
        base = beat_q.size(); d0 = done_cnt;
        start_frame(4, 2);
        send_pixels(8, 4, 2);
        wait_done(d0 + 1);
        check("e_nbeats", 32'(beat_q.size() - base), 32'd18);
        check_frame(base, 4, 2);
`ifdef CONV_FRAME_SEQ_CHK_EN
        check("e_err", 32'(err_o), 32'd2);
`else
        check("e_err", 32'(err_o), 32'd0);
`endif

        // Two 2x2 frames with enable held high
        base = beat_q.size(); d0 = done_cnt;
        en_i = 1'b1; cfg_width_i = DW'(2); cfg_height_i = DW'(2);
        send_pixels(4, 2, -1);
        send_pixels(4, 2, -1);
        wait_done(d0 + 2);
        en_i = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("f_done_pulses", 32'(done_cnt - d0),         32'd2);
        check("f_nbeats",      32'(beat_q.size() - base), 32'd20);
        check_frame(base, 2, 2);
        check_frame(base + 10, 2, 2);
        drains = 0;
        for (int j = base; j < beat_q.size(); j++) drains += int'(beat_q[j][0]);
        check("f_drain_beats", 32'(drains), 32'd12);
        check("f_idle", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
